mux_4x1_32bit: RTL and testbench
================================

MUX_4X1_32BIT -- requirements
Module: mux_4x1_32bit

Interface
REQ-001 Parameter WIDTH, default 32, data width of each input and the output; the codebase instance uses only 32.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  single clock; rising edge is the only active edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 inp1  input  WIDTH  data input selected by code 00.
REQ-006 inp2  input  WIDTH  data input selected by code 01.
REQ-007 inp3  input  WIDTH  data input selected by code 10.
REQ-008 inp4  input  WIDTH  data input selected by code 11.
REQ-009 sel0  input  1  select LSB.
REQ-010 sel1  input  1  select MSB.
REQ-011 out2  output  WIDTH  selected data.
REQ-012 Port order SHALL be: clk, rst_n, inp1, inp2, inp3, inp4, sel0, sel1, out2.

Function
REQ-013 The select code SHALL be {sel1,sel0}, mapped as 00->inp1, 01->inp2, 10->inp3, 11->inp4, with all WIDTH bits passed unmodified.
REQ-014 Without the configuration macro, out2 SHALL be purely combinational with zero-cycle latency, and any input or select change SHALL propagate in the same delta cycle.
REQ-015 Selection SHALL be two-level: level 1 uses sel0 to pick inp1/inp2 and inp3/inp4; level 2 uses sel1 to pick between the level-1 results.
REQ-016 If either select bit is X or Z, out2 SHALL be all-X in simulation, never a silently chosen input.
REQ-017 Simultaneous changes of sel0 and sel1 SHALL settle directly to the newly coded input, and no transient value SHALL be required or checked.
REQ-018 Unselected inputs SHALL have no effect on out2.

Reset
REQ-019 Without the macro, rst_n and clk SHALL NOT affect out2, since there is no state.
REQ-020 With the macro, asserting rst_n low SHALL clear out2 to all zeros immediately (asynchronously), independent of clk.
REQ-021 With the macro, deassertion of rst_n SHALL take effect at the next rising edge of clk, and the first captured value SHALL appear one cycle after deassertion.
REQ-022 With the macro, a reset asserted mid-operation SHALL discard the held value, and no pending value SHALL survive reset.

Configuration
REQ-023 Macro MUX_OUT_REG_EN SHALL, when defined, add a WIDTH-bit output register clocked by clk that captures the selected data each rising edge, giving out2 a latency of exactly 1 cycle.
REQ-024 When MUX_OUT_REG_EN is undefined, no flip-flops SHALL be inferred and out2 SHALL follow REQ-014.

Structure
REQ-025 A shared package mux_pkg SHALL hold: the WIDTH default constant (32); the select-code constants SEL_INP1=2'b00, SEL_INP2=2'b01, SEL_INP3=2'b10, SEL_INP4=2'b11; and the reset value constant (all zeros).
REQ-026 One sub-module, mux_2x1_32bit (WIDTH-parameterised, inputs a, b, sel; output y = sel ? b : a), SHALL be instantiated three times to build REQ-015.
REQ-027 The output register, when present, SHALL live in the top module, not in the sub-module.

Verification
REQ-028 inp1=32'hFFFC0000, inp2=32'h1, inp3=32'h2, inp4=32'h3; {sel1,sel0}=00 -> out2=32'hFFFC0000.
REQ-029 Same inputs; {sel1,sel0} stepped 01, 10, 11 at 100-time-unit intervals -> out2 = 32'h1, then 32'h2, then 32'h3.
REQ-030 Select held at 10; inp1, inp2 and inp4 toggled to random values -> out2 remains equal to inp3 throughout.
REQ-031 Select changed 00->11 in one step -> out2 = 32'h3 with no intermediate value sampled.
REQ-032 MUX_OUT_REG_EN defined; rst_n=0 -> out2=0 without a clock edge; release rst_n, select 01 -> out2=32'h1 after the first rising edge, not before.
REQ-033 MUX_OUT_REG_EN defined; rst_n asserted while out2=32'h3 -> out2=0 immediately, and stays 0 until one edge after release.

Source files
------------

// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared constants for the 4:1 data multiplexer.
//   WIDTH_DEFAULT : default data width of every mux input and output
//   SEL_INP1..4   : {sel1,sel0} codes selecting inp1..inp4
//   RST_VAL       : value loaded into the optional output register on reset
// -----------------------------------------------------------------------------
package mux_pkg;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic [1:0] SEL_INP1 = 2'b00;
    localparam logic [1:0] SEL_INP2 = 2'b01;
    localparam logic [1:0] SEL_INP3 = 2'b10;
    localparam logic [1:0] SEL_INP4 = 2'b11;

    localparam logic [WIDTH_DEFAULT-1:0] RST_VAL = '0;

endpackage : mux_pkg

// File: rtl/mux_2x1_32bit.sv
// -----------------------------------------------------------------------------
// mux_2x1_32bit
// WIDTH-bit 2:1 multiplexer, y = sel ? b : a.
// Ports:
//   a   : input  [WIDTH-1:0]  selected when sel = 0
//   b   : input  [WIDTH-1:0]  selected when sel = 1
//   sel : input               select
//   y   : output [WIDTH-1:0]  selected data
// -----------------------------------------------------------------------------
module mux_2x1_32bit
    import mux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    // An unknown select drives all-X in simulation rather than the bitwise
    // merge a plain ternary would give; in hardware the last branch is a
    // don't-care and collapses to a normal 2:1 mux.
    always_comb begin
        y = 'x;
        if (sel == 1'b1) begin
            y = b;
        end else if (sel == 1'b0) begin
            y = a;
        end else begin
            y = 'x;
        end
    end

endmodule : mux_2x1_32bit

// File: rtl/mux_4x1_32bit.sv
// -----------------------------------------------------------------------------
// mux_4x1_32bit
// WIDTH-bit 4:1 multiplexer built as a two-level tree of 2:1 muxes.
// Select code {sel1,sel0}: 00 -> inp1, 01 -> inp2, 10 -> inp3, 11 -> inp4.
// Optional feature macro: MUX_OUT_REG_EN
//   undefined : out2 is purely combinational, clk/rst_n have no effect
//   defined   : out2 is registered on rising clk (1-cycle latency),
//               cleared asynchronously while rst_n is low
// Ports:
//   clk   : input               clock (used only with MUX_OUT_REG_EN)
//   rst_n : input               async active-low reset (MUX_OUT_REG_EN only)
//   inp1  : input  [WIDTH-1:0]  data for code 00
//   inp2  : input  [WIDTH-1:0]  data for code 01
//   inp3  : input  [WIDTH-1:0]  data for code 10
//   inp4  : input  [WIDTH-1:0]  data for code 11
//   sel0  : input               select LSB
//   sel1  : input               select MSB
//   out2  : output [WIDTH-1:0]  selected data
// -----------------------------------------------------------------------------
module mux_4x1_32bit
    import mux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    input  logic [WIDTH-1:0] inp3,
    input  logic [WIDTH-1:0] inp4,
    input  logic             sel0,
    input  logic             sel1,
    output logic [WIDTH-1:0] out2
);

    logic [WIDTH-1:0] lvl1_lo;
    logic [WIDTH-1:0] lvl1_hi;
    logic [WIDTH-1:0] mux_out;

    mux_2x1_32bit #(.WIDTH(WIDTH)) u_mux_lo (
        .a   (inp1),
        .b   (inp2),
        .sel (sel0),
        .y   (lvl1_lo)
    );

    mux_2x1_32bit #(.WIDTH(WIDTH)) u_mux_hi (
        .a   (inp3),
        .b   (inp4),
        .sel (sel0),
        .y   (lvl1_hi)
    );

    mux_2x1_32bit #(.WIDTH(WIDTH)) u_mux_out (
        .a   (lvl1_lo),
        .b   (lvl1_hi),
        .sel (sel1),
        .y   (mux_out)
    );

`ifdef MUX_OUT_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out2 <= WIDTH'(RST_VAL);
        end else begin
            out2 <= mux_out;
        end
    end
`else
    // No state in this build: clk and rst_n are intentionally left unused.
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst_n};

    assign out2 = mux_out;
`endif

endmodule : mux_4x1_32bit

// File: tb/tb_mux_4x1_32bit.sv
// -----------------------------------------------------------------------------
// tb_mux_4x1_32bit
// Self-checking bench for mux_4x1_32bit, covering both the combinational
// build and the MUX_OUT_REG_EN registered build.
// -----------------------------------------------------------------------------
module tb_mux_4x1_32bit;
    import mux_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] inp1, inp2, inp3, inp4;
    logic         sel0, sel1;
    logic [W-1:0] out2;

    int n_chk  = 0;
    int n_pass = 0;

    mux_4x1_32bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .inp1  (inp1),
        .inp2  (inp2),
        .inp3  (inp3),
        .inp4  (inp4),
        .sel0  (sel0),
        .sel1  (sel1),
        .out2  (out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the select code is simply an index into the list of inputs.
    function automatic logic [W-1:0] ref_mux(input logic [1:0] code,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [W-1:0] c,
                                             input logic [W-1:0] d);
        logic [W-1:0] pool [4];
        pool[0] = a;
        pool[1] = b;
        pool[2] = c;
        pool[3] = d;
        return pool[int'(code)];
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: out2=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_sel(input logic [1:0] code);
        {sel1, sel0} = code;
    endtask

    task automatic rand_inputs();
        inp1 = $urandom;
        inp2 = $urandom;
        inp3 = $urandom;
        inp4 = $urandom;
    endtask

    initial begin
        logic [1:0]   code;
        logic [W-1:0] exp_q;

        rst_n = 1'b0;
        inp1 = 32'hFFFC0000;
        inp2 = 32'h1;
        inp3 = 32'h2;
        inp4 = 32'h3;
        set_sel(SEL_INP1);

`ifndef MUX_OUT_REG_EN
        // Stateless build: reset and clock must not influence the output.
        #1 chk("reset_no_effect", out2, 32'hFFFC0000);
        rst_n = 1'b1;
        #1 chk("sel00", out2, 32'hFFFC0000);

        #98 set_sel(SEL_INP2);
        #1  chk("sel01", out2, 32'h1);
        #99 set_sel(SEL_INP3);
        #1  chk("sel10", out2, 32'h2);
        #99 set_sel(SEL_INP4);
        #1  chk("sel11", out2, 32'h3);

        // Unselected inputs toggling must not disturb inp3 selection.
        set_sel(SEL_INP3);
        for (int i = 0; i < 20; i++) begin
            #3;
            inp1 = $urandom;
            inp2 = $urandom;
            inp4 = $urandom;
            #1 chk("hold_inp3", out2, 32'h2);
        end

        // Both select bits flip in one step.
        inp1 = 32'hFFFC0000; inp2 = 32'h1; inp3 = 32'h2; inp4 = 32'h3;
        set_sel(SEL_INP1);
        #1 chk("pre_jump", out2, 32'hFFFC0000);
        set_sel(SEL_INP4);
        #1 chk("jump_00_11", out2, 32'h3);

        // Clock edges and reset pulses leave the output alone.
        @(posedge clk); #1 chk("clk_no_effect", out2, 32'h3);
        rst_n = 1'b0;
        #1 chk("rst_low_no_effect", out2, 32'h3);
        @(posedge clk); #1 chk("rst_clk_no_effect", out2, 32'h3);
        rst_n = 1'b1;

        // Random vectors against the reference.
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            code = 2'($urandom_range(0, 3));
            set_sel(code);
            #1 chk("random", out2, ref_mux(code, inp1, inp2, inp3, inp4));
            #2;
        end
`else
        // Registered build.
        #1 chk("reset_async", out2, '0);
        @(negedge clk);
        rst_n = 1'b1;
        set_sel(SEL_INP2);
        #1 chk("pre_first_edge", out2, '0);
        @(posedge clk); #1 chk("first_edge", out2, 32'h1);

        // Latency 1 on random traffic.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            rand_inputs();
            code = 2'($urandom_range(0, 3));
            set_sel(code);
            exp_q = ref_mux(code, inp1, inp2, inp3, inp4);
            @(posedge clk); #1 chk("random_reg", out2, exp_q);
        end

        // Reset mid-operation while holding 3.
        @(negedge clk);
        inp1 = 32'hFFFC0000; inp2 = 32'h1; inp3 = 32'h2; inp4 = 32'h3;
        set_sel(SEL_INP4);
        @(posedge clk); #1 chk("hold3", out2, 32'h3);
        #1 rst_n = 1'b0;
        #1 chk("mid_reset_async", out2, '0);
        @(posedge clk); #1 chk("reset_held", out2, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_release_pre_edge", out2, '0);
        @(posedge clk); #1 chk("post_release_edge", out2, 32'h3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_mux_4x1_32bit
